pwm_ramp_gen: RTL
=================

Name: pwm_ramp_gen

Overview:
Parametrised PWM ramp generator. It is the next-generation replacement for the fixed 75/50/25% motor deceleration sequencer. Duty moves from a latched start duty to a latched end duty in fixed-size steps at a configurable step interval, so one block covers both acceleration and deceleration. It adds abort, optional hold-at-end, and a current-duty readback, and sits between the drive-control FSM and the motor PWM pin.

Parameters:
PERIOD, 100, PWM period in clk_1mhz cycles (100 = 10 kHz)
DUTY_W, 7, width of duty/step values; must satisfy 2^DUTY_W > PERIOD
STEP_PERIODS, 3333, PWM periods spent at each duty level
STEP_W, 14, width of the step-interval period counter; must satisfy 2^STEP_W >= STEP_PERIODS

Ports:
clk_1mhz  in  1  system clock, 1 MHz
reset_n  in  1  asynchronous active-low reset
start  in  1  level request; sampled in IDLE
abort  in  1  synchronous abort, highest priority after reset
start_duty  in  DUTY_W  first duty level, in PWM-period ticks
end_duty  in  DUTY_W  final duty level, in ticks
step_size  in  DUTY_W  duty change per step
hold_on_done  in  1  1 = keep driving end_duty in DONE; 0 = output low
pwm_signal  out  1  registered PWM output
ramp_active  out  1  high in RUN
ramp_done  out  1  high in DONE
duty_out  out  DUTY_W  duty currently applied; 0 in IDLE

Behaviour:
- Clock and reset: one clock, clk_1mhz. reset_n is asynchronous and active-low.
- Reset: all outputs and state clear to 0; state = IDLE. This also applies mid-RUN and mid-DONE.
- States: IDLE, RUN, DONE.
- Config latching:
  - On the edge where state == IDLE, start == 1 and abort == 0: latch start_duty, end_duty, step_size and hold_on_done.
  - Duty values above PERIOD clamp to PERIOD. step_size == 0 is latched as 1.
  - On the same edge: duty = start_duty, phase = 0, period_cnt = 0, state goes to RUN.
  - Input changes after latching are ignored until the next start.
- RUN:
  - phase counts 0..PERIOD-1 and wraps.
  - period_cnt increments on phase wrap.
  - Registered output: pwm_signal(n+1) = (phase(n) < duty(n)). First high cycle is the cycle after the start edge, provided start_duty > 0.
- Step boundary: when phase == PERIOD-1 and period_cnt == STEP_PERIODS-1.
  - If duty == end_duty, go to DONE.
  - Otherwise move duty toward end_duty by step_size, clamped so it never overshoots end_duty. Then period_cnt = 0 and phase wraps to 0.
- Ramp direction comes from comparing the latched start_duty with end_duty (accelerate if end > start).
- start_duty == end_duty gives exactly one step interval, then DONE.
- RUN length = (number of distinct duty levels) × STEP_PERIODS × PERIOD cycles.
- DONE:
  - ramp_done = 1, ramp_active = 0.
  - If the latched hold is set: PWM keeps running at end_duty and duty_out = end_duty.
  - If not: pwm_signal = 0 and duty_out = end_duty.
  - Leave to IDLE on the first edge with start == 0. No restart while start stays high; a retrigger needs start low for at least 1 cycle.
- abort:
  - In RUN or DONE: next edge goes to IDLE; pwm_signal, duty_out, ramp_active and ramp_done all = 0.
  - abort and start together in IDLE: stay in IDLE.
- IDLE: pwm_signal = 0 and duty_out = 0 regardless of start.
- Duty 0 gives a constant-low output. Duty == PERIOD gives a constant-high output with no glitch at the phase wrap.

Test Plan:
Tests override PERIOD=10, STEP_PERIODS=3.
- Decel: start_duty=8, end_duty=2, step=3, hold=0, start held high. Required response:
  - Levels are 8, 5, 2, each lasting 30 cycles; pwm is high 8/5/2 cycles per period.
  - ramp_done rises 90 cycles after the start edge; pwm is 0 afterwards.
  - After start drops, the block is in IDLE 1 edge later.
- Accel with clamp: start_duty=1, end_duty=9, step=5. Required response: levels 1, 6, 9; done after 90 cycles. With hold=1, pwm continues at 9/10 in DONE.
- Abort: assert abort at cycle 40 of the decel case. Required response: next cycle pwm=0, ramp_active=0, ramp_done=0, duty_out=0; no done pulse afterwards.
- Async reset: drive reset_n low mid-period, asynchronously to the clock. Required response: all outputs 0 immediately; after release, the next start behaves as a fresh run.
- Edge cases:
  - start_duty=end_duty=10: pwm constant high for 30 cycles, then DONE.
  - step=0 from 3 to 5: levels 3, 4, 5.
  - start_duty=0: pwm stays low during the first level.
- Retrigger: keep start high through DONE. Required response: no restart. Drop start for 1 cycle, then raise it: a new run begins, using the new inputs latched on that edge.

Source files
------------

// File: rtl/pwm_ramp_gen.sv
// ---------------------------------------------------------------------------
// pwm_ramp_gen
//
// Purpose:
//   PWM ramp generator. On a start request it latches a start duty, an end
//   duty, a step size and a hold flag. It then runs a PWM of PERIOD clock
//   ticks. Every STEP_PERIODS PWM periods it moves the duty toward the end
//   duty by the step size, never overshooting. Once the end duty has been
//   applied for a full step interval, it enters DONE. In DONE it either keeps
//   driving the end duty (hold) or parks the output low. It then waits for
//   start to drop before returning to IDLE. The same block handles both
//   acceleration and deceleration.
//
// Ports:
//   clk_1mhz      in   system clock
//   reset_n       in   asynchronous active-low reset
//   start         in   level request, sampled only in IDLE
//   abort         in   synchronous abort back to IDLE (beats start)
//   start_duty    in   first duty level in PWM ticks (clamped to PERIOD)
//   end_duty      in   final duty level in PWM ticks (clamped to PERIOD)
//   step_size     in   duty change per step (0 is treated as 1)
//   hold_on_done  in   1 = keep PWM running at end duty while in DONE
//   pwm_signal    out  registered PWM output
//   ramp_active   out  high while ramping (RUN)
//   ramp_done     out  high in DONE
//   duty_out      out  duty currently applied, 0 in IDLE
// ---------------------------------------------------------------------------
module pwm_ramp_gen #(
  parameter int PERIOD       = 100,
  parameter int DUTY_W       = 7,
  parameter int STEP_PERIODS = 3333,
  parameter int STEP_W       = 14
) (
  input  logic              clk_1mhz,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DUTY_W-1:0] start_duty,
  input  logic [DUTY_W-1:0] end_duty,
  input  logic [DUTY_W-1:0] step_size,
  input  logic              hold_on_done,
  output logic              pwm_signal,
  output logic              ramp_active,
  output logic              ramp_done,
  output logic [DUTY_W-1:0] duty_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DUTY_W-1:0] PERIOD_D   = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] PHASE_LAST = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] ONE_D      = DUTY_W'(1);
  localparam logic [DUTY_W-1:0] ZERO_D     = '0;
  localparam logic [STEP_W-1:0] CNT_LAST   = STEP_W'(STEP_PERIODS - 1);
  localparam logic [STEP_W-1:0] ONE_C      = STEP_W'(1);

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] phase_q, phase_d;
  logic [STEP_W-1:0] periodCnt_q, periodCnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] endDuty_q, endDuty_d;
  logic [DUTY_W-1:0] stepSize_q, stepSize_d;
  logic              hold_q, hold_d;
  logic              up_q, up_d;
  logic              pwm_q, pwm_d;
  logic              active_q, done_q;
  logic [DUTY_W-1:0] dutyOut_q;

  logic [DUTY_W-1:0] startClamped, endClamped;
  logic [DUTY_W-1:0] gap, steppedDuty;
  logic [DUTY_W-1:0] phaseNext;
  logic              phaseWrap;

  // Requested duties above one full period make no sense; saturate them.
  function automatic logic [DUTY_W-1:0] clampDuty(input logic [DUTY_W-1:0] v);
    return (v > PERIOD_D) ? PERIOD_D : v;
  endfunction

  assign startClamped = clampDuty(start_duty);
  assign endClamped   = clampDuty(end_duty);

  // The distance left to the end duty decides whether a full step fits.
  // If it does not fit, land exactly on the end duty. This also rules out
  // wrap-around in either direction.
  assign gap         = up_q ? (endDuty_q - duty_q) : (duty_q - endDuty_q);
  assign steppedDuty = (gap <= stepSize_q) ? endDuty_q
                     : (up_q ? (duty_q + stepSize_q) : (duty_q - stepSize_q));

  assign phaseWrap = (phase_q == PHASE_LAST);
  assign phaseNext = phaseWrap ? ZERO_D : (phase_q + ONE_D);

  // Next-state logic for the ramp sequencer. pwm_d is the comparison of the
  // current phase and duty. It is registered, so the pin lags the counters
  // by one cycle.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    periodCnt_d = periodCnt_q;
    duty_d      = duty_q;
    endDuty_d   = endDuty_q;
    stepSize_d  = stepSize_q;
    hold_d      = hold_q;
    up_d        = up_q;
    pwm_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d     = RUN;
          duty_d      = startClamped;
          endDuty_d   = endClamped;
          stepSize_d  = (step_size == ZERO_D) ? ONE_D : step_size;
          hold_d      = hold_on_done;
          up_d        = (endClamped > startClamped);
          phase_d     = ZERO_D;
          periodCnt_d = '0;
        end
      end

      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          pwm_d   = (phase_q < duty_q);
          phase_d = phaseNext;
          if (phaseWrap) begin
            if (periodCnt_q == CNT_LAST) begin
              periodCnt_d = '0;
              if (duty_q == endDuty_q) begin
                state_d = DONE;
              end else begin
                duty_d = steppedDuty;
              end
            end else begin
              periodCnt_d = periodCnt_q + ONE_C;
            end
          end
        end
      end

      DONE: begin
        if (abort || !start) begin
          state_d = IDLE;
        end else begin
          pwm_d   = hold_q && (phase_q < duty_q);
          phase_d = phaseNext;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs. The status flags and duty readback are
  // decoded from the next state, so they change on the same edge as the
  // state itself.
  always_ff @(posedge clk_1mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      periodCnt_q <= '0;
      duty_q      <= '0;
      endDuty_q   <= '0;
      stepSize_q  <= '0;
      hold_q      <= 1'b0;
      up_q        <= 1'b0;
      pwm_q       <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      dutyOut_q   <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      periodCnt_q <= periodCnt_d;
      duty_q      <= duty_d;
      endDuty_q   <= endDuty_d;
      stepSize_q  <= stepSize_d;
      hold_q      <= hold_d;
      up_q        <= up_d;
      pwm_q       <= pwm_d;
      active_q    <= (state_d == RUN);
      done_q      <= (state_d == DONE);
      dutyOut_q   <= (state_d == IDLE) ? ZERO_D : duty_d;
    end
  end

  assign pwm_signal  = pwm_q;
  assign ramp_active = active_q;
  assign ramp_done   = done_q;
  assign duty_out    = dutyOut_q;

endmodule
